// File: rtl/uc_mem_cmd_sequencer.sv
// uc_mem_cmd_sequencer
//   Accepts serial command frames from a microcontroller on asynchronous pins,
//   synchronises them into the clk_i domain, checks the frame length and runs a
//   single memory read or write. Read data (or the echoed write data) is shifted
//   back to the uC MSB-first during the following frame.
//
//   Frame: op (1 = write, 0 = read), address MSB-first, data MSB-first.
//
//   Optional build macro UC_CMD_PARITY_EN: frames carry one trailing odd-parity
//   bit, and the readback word gains an odd-parity bit after the data bits.
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous active-high reset
//   uc_sclk_i    uC serial clock (async)
//   uc_sdata_i   uC serial data, sampled on synchronised uc_sclk_i rise
//   uc_cs_ni     uC frame select, active low (async)
//   uc_sdata_o   readback bit, updated after each synchronised uc_sclk_i fall
//   mem_addr_o   memory address, held until the next transaction
//   mem_data_o   memory write data, held until the next transaction
//   mem_wr_no    memory write enable, active low, one-cycle pulse
//   mem_data_i   memory read data, valid READ_LATENCY cycles after address
//   busy_o       high from frame accept until the transaction completes
//   done_o       one-cycle pulse on completion
//   frame_err_o  sticky bad-frame flag, cleared by the next good transaction

module uc_mem_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  uc_sclk_i,
  input  logic                  uc_sdata_i,
  input  logic                  uc_cs_ni,
  output logic                  uc_sdata_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wr_no,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  frame_err_o
);

  localparam int unsigned FRAME_BITS = 1 + ADDR_WIDTH + DATA_WIDTH;
`ifdef UC_CMD_PARITY_EN
  localparam int unsigned FRAME_LEN  = FRAME_BITS + 1;
  localparam int unsigned TX_BITS    = DATA_WIDTH + 1;
`else
  localparam int unsigned FRAME_LEN  = FRAME_BITS;
  localparam int unsigned TX_BITS    = DATA_WIDTH;
`endif
  // Counter must reach FRAME_LEN+1 so an over-long frame stays distinguishable.
  localparam int unsigned CNT_W = $clog2(FRAME_LEN + 2);
  localparam int unsigned LAT_W = 2;

  typedef enum logic [2:0] {StIdle, StShift, StExec, StWaitRd, StDone} state_e;

  // Synchronisers; cs_n resets high so releasing reset never fakes a frame start.
  logic [1:0] r_sclk_sync, r_sdata_sync, r_csn_sync;
  logic       r_sclk_prev, r_csn_prev;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sclk_sync  <= 2'b00;
      r_sdata_sync <= 2'b00;
      r_csn_sync   <= 2'b11;
      r_sclk_prev  <= 1'b0;
      r_csn_prev   <= 1'b1;
    end else begin
      r_sclk_sync  <= {r_sclk_sync[0], uc_sclk_i};
      r_sdata_sync <= {r_sdata_sync[0], uc_sdata_i};
      r_csn_sync   <= {r_csn_sync[0], uc_cs_ni};
      r_sclk_prev  <= r_sclk_sync[1];
      r_csn_prev   <= r_csn_sync[1];
    end
  end

  logic w_sclk_rise, w_sclk_fall, w_csn_fall, w_csn_rise, w_sdata;
  assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_prev;
  assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_prev;
  assign w_csn_fall  = ~r_csn_sync[1] & r_csn_prev;
  assign w_csn_rise  = r_csn_sync[1] & ~r_csn_prev;
  assign w_sdata     = r_sdata_sync[1];

  state_e                r_state;
  logic [FRAME_LEN-1:0]  r_rx_sr;
  logic [CNT_W-1:0]      r_bit_cnt;
  logic [TX_BITS-2:0]    r_tx_sr;    // readback bits still to be sent
  logic                  r_sdata_o;
  logic [DATA_WIDTH-1:0] r_rdback;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_data;
  logic                  r_wr_n;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_frame_err;
  logic [LAT_W-1:0]      r_lat;

  // Frame fields, MSB-aligned in the receive shifter.
  logic                  w_op;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_frame_ok;
  logic [TX_BITS-1:0]    w_tx_word;

  assign w_op   = r_rx_sr[FRAME_LEN-1];
  assign w_addr = r_rx_sr[FRAME_LEN-2 -: ADDR_WIDTH];
  assign w_data = r_rx_sr[FRAME_LEN-2-ADDR_WIDTH -: DATA_WIDTH];

`ifdef UC_CMD_PARITY_EN
  // Odd parity over the whole frame including the parity bit.
  assign w_frame_ok = (r_bit_cnt == CNT_W'(FRAME_LEN)) && (^r_rx_sr);
  assign w_tx_word  = {r_rdback, ~^r_rdback};
`else
  assign w_frame_ok = (r_bit_cnt == CNT_W'(FRAME_LEN));
  assign w_tx_word  = r_rdback;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_rx_sr     <= '0;
      r_bit_cnt   <= '0;
      r_tx_sr     <= '0;
      r_sdata_o   <= 1'b0;
      r_rdback    <= '0;
      r_mem_addr  <= '0;
      r_mem_data  <= '0;
      r_wr_n      <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_err <= 1'b0;
      r_lat       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          // cs_n edges seen outside StIdle are dropped, so a frame started
          // while busy is lost as a whole.
          if (w_csn_fall) begin
            r_state   <= StShift;
            r_rx_sr   <= '0;
            r_bit_cnt <= '0;
            r_sdata_o <= w_tx_word[TX_BITS-1];
            r_tx_sr   <= w_tx_word[TX_BITS-2:0];
          end
        end
        StShift: begin
          if (w_csn_rise) begin
            r_sdata_o <= 1'b0;
            if (w_frame_ok) begin
              r_state    <= StExec;
              r_busy     <= 1'b1;
              r_mem_addr <= w_addr;
              r_mem_data <= w_data;
            end else begin
              r_state     <= StIdle;
              r_frame_err <= 1'b1;
            end
          end else begin
            if (w_sclk_rise) begin
              r_rx_sr <= {r_rx_sr[FRAME_LEN-2:0], w_sdata};
              if (r_bit_cnt != CNT_W'(FRAME_LEN + 1)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
              end
            end
            if (w_sclk_fall) begin
              r_sdata_o <= r_tx_sr[TX_BITS-2];
              r_tx_sr   <= {r_tx_sr[TX_BITS-3:0], 1'b0};
            end
          end
        end
        StExec: begin
          if (w_op) begin
            r_wr_n   <= 1'b0;
            r_rdback <= r_mem_data;  // write echoes its data on the next frame
            r_state  <= StDone;
          end else begin
            r_lat   <= '0;
            r_state <= StWaitRd;
          end
        end
        StWaitRd: begin
          // Address became valid on entry to StExec; capture on the edge that
          // follows the READ_LATENCY-th cycle.
          if (r_lat == LAT_W'(READ_LATENCY - 1)) begin
            r_rdback <= mem_data_i;
            r_state  <= StDone;
          end else begin
            r_lat <= r_lat + LAT_W'(1);
          end
        end
        StDone: begin
          r_wr_n      <= 1'b1;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_frame_err <= 1'b0;
          r_state     <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign uc_sdata_o  = r_sdata_o;
  assign mem_addr_o  = r_mem_addr;
  assign mem_data_o  = r_mem_data;
  assign mem_wr_no   = r_wr_n;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_uc_mem_cmd_sequencer.sv
`timescale 1ns/1ps

module tb_uc_mem_cmd_sequencer;

`ifdef UC_CMD_PARITY_EN
  localparam int FL = 26;
`else
  localparam int FL = 25;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0;
  logic        sdata = 1'b0;
  logic        csn = 1'b1;
  logic        uc_sdata_o;
  logic [7:0]  mem_addr_o;
  logic [15:0] mem_data_o;
  logic        mem_wr_no;
  logic [15:0] mem_data_i;
  logic        busy_o;
  logic        done_o;
  logic        frame_err_o;

  uc_mem_cmd_sequencer #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (16),
    .READ_LATENCY(2)
  ) u_dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .uc_sclk_i  (sclk),
    .uc_sdata_i (sdata),
    .uc_cs_ni   (csn),
    .uc_sdata_o (uc_sdata_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_wr_no  (mem_wr_no),
    .mem_data_i (mem_data_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o)
  );

  always #20 clk = ~clk;

  // Memory model with a two-cycle read pipeline.
  logic [15:0] mem [256];
  logic [15:0] rd_p1, rd_p2;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
      mem[8'hFF] <= 16'hA5C3;
      rd_p1 <= 16'h0000;
      rd_p2 <= 16'h0000;
    end else begin
      if (!mem_wr_no) mem[mem_addr_o] <= mem_data_o;
      rd_p1 <= mem[mem_addr_o];
      rd_p2 <= rd_p1;
    end
  end
  assign mem_data_i = rd_p2;

  // Strobe monitors.
  int   wr_cycles = 0;
  int   wr_pulses = 0;
  int   done_cnt  = 0;
  logic wr_prev   = 1'b1;
  always @(posedge clk) begin
    if (!mem_wr_no) wr_cycles++;
    if (!mem_wr_no && wr_prev) wr_pulses++;
    wr_prev = mem_wr_no;
    if (done_o) done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic shift_bit(input logic b);
    sdata = b;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (5) @(negedge clk);
    sclk = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Sends the low n bits of 'bits' MSB-first; rx gathers the first 16 readback bits.
  task automatic send_bits(input logic [31:0] bits, input int n, output logic [15:0] rx);
    csn = 1'b0;
    repeat (5) @(negedge clk);
    rx = 16'h0000;
    for (int i = n - 1; i >= 0; i--) begin
      int j;
      j = n - 1 - i;
      if (j < 16) rx[15-j] = uc_sdata_o;
      shift_bit(bits[i]);
    end
    csn = 1'b1;
  endtask

  task automatic send_cmd(input logic op, input logic [7:0] a, input logic [15:0] d,
                          output logic [15:0] rx);
    logic [31:0] f;
    f = {7'b0, op, a, d};
`ifdef UC_CMD_PARITY_EN
    f = {f[30:0], ~^{op, a, d}};
`endif
    send_bits(f, FL, rx);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " addr"}, mem_addr_o, 0);
    check({pfx, " data"}, mem_data_o, 0);
    check({pfx, " wr_n"}, mem_wr_no, 1);
    check({pfx, " sdata_o"}, uc_sdata_o, 0);
    check({pfx, " busy"}, busy_o, 0);
    check({pfx, " done"}, done_o, 0);
    check({pfx, " frame_err"}, frame_err_o, 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    int w0, p0, d0;

    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // Write 0x0055 to 0x02.
    w0 = wr_cycles; p0 = wr_pulses; d0 = done_cnt;
    send_cmd(1'b1, 8'h02, 16'h0055, rx);
    repeat (3) @(negedge clk);
    check("wr busy", busy_o, 1);
    repeat (10) @(negedge clk);
    check("wr addr", mem_addr_o, 8'h02);
    check("wr data", mem_data_o, 16'h0055);
    check("wr low cycles", wr_cycles - w0, 1);
    check("wr pulses", wr_pulses - p0, 1);
    check("wr done", done_cnt - d0, 1);
    check("wr frame_err", frame_err_o, 0);
    check("wr busy end", busy_o, 0);
    check("wr mem", mem[8'h02], 16'h0055);

    // Read 0xFF, then read it back via an empty frame.
    w0 = wr_cycles; d0 = done_cnt;
    send_cmd(1'b0, 8'hFF, 16'h0000, rx);
    check("echo readback", rx, 16'h0055);
    repeat (12) @(negedge clk);
    check("rd addr", mem_addr_o, 8'hFF);
    send_cmd(1'b0, 8'h00, 16'h0000, rx);
    check("rd readback", rx, 16'hA5C3);
    repeat (12) @(negedge clk);
    check("rd no write", wr_cycles - w0, 0);
    check("rd done", done_cnt - d0, 2);

    // Short and long frames.
    w0 = wr_cycles; d0 = done_cnt;
    send_bits(32'h0000_0000, FL - 1, rx);
    repeat (12) @(negedge clk);
    check("short err", frame_err_o, 1);
    send_bits(32'h0155_5555, FL + 1, rx);
    repeat (12) @(negedge clk);
    check("long err", frame_err_o, 1);
    check("bad no write", wr_cycles - w0, 0);
    check("bad no done", done_cnt - d0, 0);
    check("bad busy", busy_o, 0);
    send_cmd(1'b1, 8'h10, 16'h1234, rx);
    repeat (12) @(negedge clk);
    check("recover err", frame_err_o, 0);
    check("recover done", done_cnt - d0, 1);
    check("recover mem", mem[8'h10], 16'h1234);

    // Second frame starting while busy is dropped.
    w0 = wr_cycles; d0 = done_cnt;
    send_cmd(1'b1, 8'h33, 16'hBEEF, rx);
    repeat (2) @(negedge clk);
    csn = 1'b0;
    @(negedge clk);
    check("ovl busy", busy_o, 1);
    send_cmd(1'b1, 8'h44, 16'h1111, rx);
    repeat (12) @(negedge clk);
    check("ovl done", done_cnt - d0, 1);
    check("ovl wr cycles", wr_cycles - w0, 1);
    check("ovl mem first", mem[8'h33], 16'hBEEF);
    check("ovl mem second", mem[8'h44], 16'h0000);
    check("ovl addr", mem_addr_o, 8'h33);
    check("ovl data", mem_data_o, 16'hBEEF);

    // Reset in the middle of a frame.
    send_bits(32'h0000_0000, FL - 1, rx);
    repeat (12) @(negedge clk);
    check("pre-rst err", frame_err_o, 1);
    csn = 1'b0;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 10; i++) shift_bit(i[0]);
    check("pre-rst sdata", uc_sdata_o, 1);
    #7;
    reset = 1'b1;
    csn = 1'b1;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    w0 = wr_cycles; d0 = done_cnt;
    send_cmd(1'b1, 8'h5A, 16'hC0DE, rx);
    repeat (12) @(negedge clk);
    check("post-rst addr", mem_addr_o, 8'h5A);
    check("post-rst data", mem_data_o, 16'hC0DE);
    check("post-rst mem", mem[8'h5A], 16'hC0DE);
    check("post-rst wr", wr_cycles - w0, 1);
    check("post-rst done", done_cnt - d0, 1);

`ifdef UC_CMD_PARITY_EN
    // Flipped parity bit must be rejected.
    w0 = wr_cycles;
    send_bits({6'b0, 1'b1, 8'h66, 16'h00F0, ~(~^{1'b1, 8'h66, 16'h00F0})}, FL, rx);
    repeat (12) @(negedge clk);
    check("par err", frame_err_o, 1);
    check("par no write", wr_cycles - w0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
